// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter/rotator.
// Provides the 3-bit operation type and its op-code values.
package shift_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLL = 3'b000;
    localparam op_t OP_SRL = 3'b001;
    localparam op_t OP_SRA = 3'b010;
    localparam op_t OP_ROL = 3'b011;
    localparam op_t OP_ROR = 3'b100;

endpackage

// File: rtl/shift_stage.sv
// One registered stage of the shifter: shifts by DIST when its amount bit
// is set, in the selected mode, and holds the result under back-pressure.
// Ports: in_* = operation from the previous stage; out_* = registered result.
// out_ready is the successor's readiness; loading happens when the stage
// is empty or its contents leave this cycle.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  op_t                      in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_amt,
    output op_t                      out_op,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int K = $clog2(DIST);

    logic [WIDTH-1:0] shifted;
    logic             load;

    // Right shifts never change the MSB position, so the local MSB is
    // still the original operand's sign bit at every stage.
    always_comb begin
        shifted = in_data;
        if (in_amt[K]) begin
            unique case (in_op)
                OP_SLL:  shifted = in_data << DIST;
                OP_SRL:  shifted = in_data >> DIST;
                OP_SRA:  shifted = $signed(in_data) >>> DIST;
                OP_ROL:  shifted = {in_data[WIDTH-1-DIST:0],
                                    in_data[WIDTH-1:WIDTH-DIST]};
                OP_ROR:  shifted = {in_data[DIST-1:0],
                                    in_data[WIDTH-1:DIST]};
                default: shifted = in_data;
            endcase
        end
    end

    assign load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_op    <= '0;
            out_tag   <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            // Payload only moves on a real transfer so it stays quiet
            // while bubbles pass.
            if (in_valid) begin
                out_data <= shifted;
                out_amt  <= in_amt;
                out_op   <= in_op;
                out_tag  <= in_tag;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined multi-mode shifter/rotator with valid/ready at both ends.
// Ports: in_valid/in_ready/in_data/in_amt/in_op/in_tag accept an operation;
// out_valid/out_ready/out_data/out_tag return the result, one stage per
// amount bit, in order.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  op_t              in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [LOG2W:0]   vld;
    logic [LOG2W:0]   rdy;
    logic [WIDTH-1:0] dat [LOG2W+1];
    logic [LOG2W-1:0] amt [LOG2W+1];
    op_t              op  [LOG2W+1];
    logic [TAG_W-1:0] tag [LOG2W+1];
    logic             unused_tail;

    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign amt[0] = in_amt;
    assign op[0]  = in_op;
    assign tag[0] = in_tag;

    // Ready ripples back from the consumer: a stage can take new data
    // when its register is empty or its occupant moves on this cycle.
    always_comb begin
        rdy        = '0;
        rdy[LOG2W] = out_ready;
        for (int k = LOG2W - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[k]),
            .in_data   (dat[k]),
            .in_amt    (amt[k]),
            .in_op     (op[k]),
            .in_tag    (tag[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (dat[k+1]),
            .out_amt   (amt[k+1]),
            .out_op    (op[k+1]),
            .out_tag   (tag[k+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[LOG2W];
    assign out_data  = dat[LOG2W];
    assign out_tag   = tag[LOG2W];

    // Amount and op are spent once the last stage has used them.
    assign unused_tail = ^{amt[LOG2W], op[LOG2W]};

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed vectors, streaming,
// back-pressure, mid-flight reset and a 32-bit instance.
module tb_shift_pipe;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_amt, in_tag, out_tag;
    op_t         in_op;

    logic        v32, r32, ov32;
    logic [31:0] d32, od32;
    logic [4:0]  a32;
    logic [3:0]  t32, ot32;
    op_t         op32;

    shift_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    shift_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(r32),
        .in_data(d32), .in_amt(a32), .in_op(op32), .in_tag(t32),
        .out_valid(ov32), .out_ready(1'b1),
        .out_data(od32), .out_tag(ot32)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  t;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_pop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input op_t o, input logic [15:0] d,
                                          input logic [3:0] a);
        logic [31:0] dd;
        dd = {d, d};
        case (o)
            OP_SLL: return d << a;
            OP_SRL: return d >> a;
            OP_SRA: return $signed(d) >>> a;
            OP_ROL: begin dd = dd << a; return dd[31:16]; end
            OP_ROR: begin dd = dd >> a; return dd[15:0]; end
            default: return d;
        endcase
    endfunction

    // Monitor: samples between edges, pops on every output transfer.
    initial begin
        logic        hold;
        logic [15:0] hd;
        logic [3:0]  ht;
        exp_t        e;
        hold = 1'b0;
        hd = '0;
        ht = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_data", 32'(out_data), 32'(hd));
                    chk("hold_tag", 32'(out_tag), 32'(ht));
                end
                hold = out_valid && !out_ready;
                hd = out_data;
                ht = out_tag;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_out: got %h tag %h expected none",
                                 out_data, out_tag);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_tag", 32'(out_tag), 32'(e.t));
                        last_pop = cyc;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after accept.
    task automatic send(input op_t o, input logic [15:0] d,
                        input logic [3:0] a, input logic [3:0] t,
                        input logic [15:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op = o;
        in_data = d;
        in_amt = a;
        in_tag = t;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end else begin
            q.push_back('{e, t});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 0);
        @(negedge clk);
    endtask

    typedef struct {
        op_t         o;
        logic [15:0] d;
        logic [3:0]  a;
        logic [15:0] e;
    } vec_t;

    vec_t vecs[10] = '{
        '{OP_SRA, 16'h8001, 4'd1,  16'hC000},
        '{OP_SRA, 16'h7FFF, 4'd15, 16'h0000},
        '{OP_SRA, 16'h8000, 4'd15, 16'hFFFF},
        '{OP_SRL, 16'h8001, 4'd15, 16'h0001},
        '{OP_SLL, 16'h00FF, 4'd8,  16'hFF00},
        '{OP_ROL, 16'h8001, 4'd4,  16'h0018},
        '{OP_ROR, 16'h1234, 4'd4,  16'h4123},
        '{3'b111, 16'hBEEF, 4'd5,  16'hBEEF},
        '{OP_SRA, 16'h8001, 4'd0,  16'h8001},
        '{OP_ROR, 16'h1234, 4'd0,  16'h1234}
    };

    initial begin
        int n;
        int c0;
        op_t o;
        logic [15:0] d;
        logic [3:0] a;
        in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1;
        v32 = 1'b0; d32 = '0; a32 = '0; op32 = '0; t32 = '0;

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst32_out_valid", 32'(ov32), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: result visible after the 4th edge counted from accept.
        send(OP_SRA, 16'h8001, 4'd1, 4'h1, 16'hC000);
        n = 0;
        while (n < 20) begin
            #3;
            if (out_valid) break;
            @(negedge clk);
            n++;
        end
        chk("latency16", 32'(n), 3);
        drain();

        for (int i = 0; i < 10; i++)
            send(vecs[i].o, vecs[i].d, vecs[i].a, 4'(i), vecs[i].e);
        drain();

        // Streaming, one op per cycle.
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            o = op_t'($urandom_range(0, 7));
            d = 16'($urandom);
            a = 4'($urandom);
            send(o, d, a, 4'(i), model(o, d, a));
        end
        drain();
        chk("stream_cycles", 32'(last_pop - c0), 23);

        // Back-pressure.
        out_ready = 1'b0;
        send(OP_ROL, 16'hA5C3, 4'd3, 4'hA, 16'h2E1D);
        send(OP_SRL, 16'hF0F0, 4'd6, 4'hB, 16'h03C3);
        send(OP_SRA, 16'h9000, 4'd2, 4'hC, 16'hE400);
        send(OP_SLL, 16'h0F0F, 4'd5, 4'hD, 16'hE1E0);
        in_valid = 1'b1; in_op = OP_ROR; in_data = 16'h000F;
        in_amt = 4'd1; in_tag = 4'hE;
        #1;
        chk("full_in_ready", 32'(in_ready), 0);
        repeat (6) @(negedge clk);
        #1;
        chk("held_in_ready", 32'(in_ready), 0);
        chk("held_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        send(OP_ROR, 16'h000F, 4'd1, 4'hE, 16'h8007);
        drain();

        // Mid-flight reset.
        send(OP_SLL, 16'h0001, 4'd1, 4'h1, 16'h0002);
        send(OP_SLL, 16'h0001, 4'd2, 4'h2, 16'h0004);
        send(OP_SLL, 16'h0001, 4'd3, 4'h3, 16'h0008);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        q.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        send(OP_SRL, 16'h8000, 4'd15, 4'h7, 16'h0001);
        drain();

        // 32-bit instance.
        v32 = 1'b1; op32 = OP_ROL; d32 = 32'h80000001; a32 = 5'd31; t32 = 4'h9;
        #1;
        chk("w32_in_ready", 32'(r32), 1);
        @(negedge clk);
        v32 = 1'b0;
        n = 0;
        while (n < 20) begin
            #3;
            if (ov32) break;
            @(negedge clk);
            n++;
        end
        chk("w32_depth", 32'(n), 4);
        chk("w32_data", od32, 32'hC0000000);
        chk("w32_tag", 32'(ot32), 32'h9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
